// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmit scheduler: round-robin grant, frame gap,
// transmit timeout and deferred option-register updates.
module uart_tx_scheduler #(
   parameter int          GAP_CYCLES     = 16,
   parameter int          TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0]  CFG_RESET      = 8'h00
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic       req_a,
   input  logic [7:0] data_a,
   input  logic       req_b,
   input  logic [7:0] data_b,
   output logic       ack_a,
   output logic       ack_b,
   input  logic       cfg_write,
   input  logic [7:0] cfg_data,
   input  logic       tx_done,
   output logic       send_enable,
   output logic [7:0] data_to_send,
   output logic [7:0] usr_options,
   output logic       cfg_pending,
   output logic       last_grant,
   output logic       timeout_err,
   output logic       idle
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   localparam int T_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam int G_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam logic [TW-1:0] T_LAST = TW'(T_LAST_I);
   localparam logic [GW-1:0] G_LAST = GW'(G_LAST_I);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t        state;
   logic [7:0]    shadow;
   logic [TW-1:0] t_cnt;
   logic [GW-1:0] g_cnt;
   logic          pick_a;

   // On a tie the requester not served last wins.
   assign pick_a = req_a && (!req_b || last_grant);

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state        <= IDLE;
         shadow       <= CFG_RESET;
         usr_options  <= CFG_RESET;
         cfg_pending  <= 1'b0;
         send_enable  <= 1'b0;
         data_to_send <= 8'h00;
         ack_a        <= 1'b0;
         ack_b        <= 1'b0;
         timeout_err  <= 1'b0;
         last_grant   <= 1'b1;
         idle         <= 1'b1;
         t_cnt        <= '0;
         g_cnt        <= '0;
      end else begin
         ack_a       <= 1'b0;
         ack_b       <= 1'b0;
         timeout_err <= 1'b0;
         if (cfg_write) begin
            shadow      <= cfg_data;
            cfg_pending <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               // Options only move here, so never under an active frame.
               if (cfg_pending) begin
                  usr_options <= shadow;
                  if (!cfg_write)
                     cfg_pending <= 1'b0;
               end else if (req_a || req_b) begin
                  if (pick_a) begin
                     ack_a        <= 1'b1;
                     data_to_send <= data_a;
                     last_grant   <= 1'b0;
                  end else begin
                     ack_b        <= 1'b1;
                     data_to_send <= data_b;
                     last_grant   <= 1'b1;
                  end
                  send_enable <= 1'b1;
                  idle        <= 1'b0;
                  t_cnt       <= '0;
                  state       <= SEND;
               end
            end
            SEND: begin
               if (tx_done) begin
                  send_enable <= 1'b0;
                  t_cnt       <= '0;
                  g_cnt       <= '0;
                  state       <= GAP;
               end else if (t_cnt == T_LAST) begin
                  send_enable <= 1'b0;
                  timeout_err <= 1'b1;
                  t_cnt       <= '0;
                  g_cnt       <= '0;
                  state       <= GAP;
               end else begin
                  t_cnt <= t_cnt + TW'(1);
               end
            end
            GAP: begin
               if (g_cnt == G_LAST) begin
                  g_cnt <= '0;
                  idle  <= 1'b1;
                  state <= IDLE;
               end else begin
                  g_cnt <= g_cnt + GW'(1);
               end
            end
            default: begin
               send_enable <= 1'b0;
               idle        <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: grant, arbitration, gap,
// deferred configuration, timeout and reset abort.
module tb_uart_tx_scheduler;

   logic       sys_clk = 1'b0;
   logic       reset;
   logic       req_a, req_b, cfg_write, tx_done;
   logic [7:0] data_a, data_b, cfg_data;
   logic       ack_a, ack_b, send_enable, cfg_pending;
   logic       last_grant, timeout_err, idle;
   logic [7:0] data_to_send, usr_options;

   int n_cmp = 0;
   int n_err = 0;

   uart_tx_scheduler #(
      .GAP_CYCLES(16),
      .TIMEOUT_CYCLES(50),
      .CFG_RESET(8'h00)
   ) dut (
      .sys_clk(sys_clk), .reset(reset),
      .req_a(req_a), .data_a(data_a),
      .req_b(req_b), .data_b(data_b),
      .ack_a(ack_a), .ack_b(ack_b),
      .cfg_write(cfg_write), .cfg_data(cfg_data),
      .tx_done(tx_done),
      .send_enable(send_enable), .data_to_send(data_to_send),
      .usr_options(usr_options), .cfg_pending(cfg_pending),
      .last_grant(last_grant), .timeout_err(timeout_err),
      .idle(idle)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Ticks until an ack appears; n is ticks taken, -1 on timeout.
   task automatic wait_ack(output int n);
      n = -1;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (ack_a || ack_b) begin
            n = i;
            break;
         end
      end
   endtask

   int n;
   int cnt;
   logic [1:0] exp_ack;
   logic [7:0] exp_dat;

   initial begin
      reset = 1'b1; req_a = 0; req_b = 0; cfg_write = 0; tx_done = 0;
      data_a = 0; data_b = 0; cfg_data = 0;
      tick(); tick();
      chk("rst_idle", idle, 1);
      chk("rst_se", send_enable, 0);
      chk("rst_dat", data_to_send, 8'h00);
      chk("rst_opt", usr_options, 8'h00);
      chk("rst_pend", cfg_pending, 0);
      chk("rst_lg", last_grant, 1);
      chk("rst_ack", {ack_a, ack_b}, 2'b00);
      chk("rst_to", timeout_err, 0);

      // Single send from A
      reset = 0; req_a = 1; data_a = 8'h55;
      tick();
      chk("a_ack", {ack_a, ack_b}, 2'b10);
      chk("a_se", send_enable, 1);
      chk("a_dat", data_to_send, 8'h55);
      chk("a_idle", idle, 0);
      chk("a_lg", last_grant, 0);
      req_a = 0;
      repeat (5) tick();
      chk("a_hold_se", send_enable, 1);
      chk("a_hold_dat", data_to_send, 8'h55);
      chk("a_ack_pulse", ack_a, 0);
      tx_done = 1;
      tick();
      tx_done = 0;
      chk("a_done_se", send_enable, 0);
      chk("a_gap_idle", idle, 0);
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         tx_done = (i == 4);
         tick();
         if (idle || send_enable) cnt++;
      end
      tx_done = 0;
      chk("a_gap_len", cnt, 0);
      tick();
      chk("a_gap_end", idle, 1);

      // Both requesting: A,B,A,B from reset
      reset = 1; tick(); reset = 0;
      req_a = 1; req_b = 1; data_a = 8'hA1; data_b = 8'hB2;
      for (int g = 0; g < 4; g++) begin
         wait_ack(n);
         exp_ack = (g % 2 == 0) ? 2'b10 : 2'b01;
         exp_dat = (g % 2 == 0) ? 8'hA1 : 8'hB2;
         chk("rr_ack", {ack_a, ack_b}, exp_ack);
         chk("rr_dat", data_to_send, exp_dat);
         chk("rr_lg", last_grant, (g % 2 == 0) ? 0 : 1);
         if (g > 0) chk("rr_space", n, 17);
         repeat (9) tick();
         tx_done = 1; tick(); tx_done = 0;
      end
      req_a = 0; req_b = 0;
      repeat (16) tick();
      chk("rr_idle", idle, 1);

      // Config written during SEND applies after the gap
      req_a = 1; data_a = 8'h3C;
      tick();
      chk("c_ack", ack_a, 1);
      req_a = 0;
      cfg_write = 1; cfg_data = 8'hC3;
      req_b = 1; data_b = 8'h77;
      tick();
      cfg_write = 0;
      chk("c_pend", cfg_pending, 1);
      chk("c_opt_send", usr_options, 8'h00);
      repeat (3) tick();
      tx_done = 1; tick(); tx_done = 0;
      repeat (15) tick();
      chk("c_opt_gap", usr_options, 8'h00);
      tick();
      chk("c_idle", idle, 1);
      chk("c_opt_first", usr_options, 8'h00);
      tick();
      chk("c_opt_apply", usr_options, 8'hC3);
      chk("c_pend_clr", cfg_pending, 0);
      chk("c_no_ack", {ack_a, ack_b}, 2'b00);
      tick();
      chk("c_ack_b", {ack_a, ack_b}, 2'b01);
      chk("c_dat_b", data_to_send, 8'h77);
      req_b = 0;

      // Two writes in one SEND, then a write in the apply cycle
      cfg_write = 1; cfg_data = 8'h40; tick();
      cfg_data = 8'h80; tick();
      cfg_write = 0;
      tx_done = 1; tick(); tx_done = 0;
      repeat (16) tick();
      chk("w_idle", idle, 1);
      chk("w_opt_keep", usr_options, 8'hC3);
      cfg_write = 1; cfg_data = 8'h11;
      tick();
      cfg_write = 0;
      chk("w_opt_last", usr_options, 8'h80);
      chk("w_pend_set", cfg_pending, 1);
      tick();
      chk("w_opt_new", usr_options, 8'h11);
      chk("w_pend_clr", cfg_pending, 0);

      // Timeout after 50 SEND cycles
      req_a = 1; data_a = 8'h5A;
      tick();
      chk("t_ack", ack_a, 1);
      req_a = 0;
      cnt = 0;
      for (int i = 0; i < 49; i++) begin
         tick();
         if (send_enable && !timeout_err) cnt++;
      end
      chk("t_send_len", cnt, 49);
      tick();
      chk("t_se_drop", send_enable, 0);
      chk("t_err", timeout_err, 1);
      tick();
      chk("t_err_pulse", timeout_err, 0);
      repeat (14) tick();
      chk("t_gap", idle, 0);
      tick();
      chk("t_idle", idle, 1);

      // Reset in the middle of SEND
      req_b = 1; data_b = 8'h99;
      tick();
      chk("r_ack", ack_b, 1);
      req_b = 0;
      repeat (3) tick();
      reset = 1;
      tick();
      chk("r_se", send_enable, 0);
      chk("r_opt", usr_options, 8'h00);
      chk("r_dat", data_to_send, 8'h00);
      chk("r_idle", idle, 1);
      reset = 0;
      tick(); tick();
      chk("r_no_ack", {ack_a, ack_b}, 2'b00);
      chk("r_no_se", send_enable, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 16: idle sys_clk cycles enforced between consecutive frames.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000: sys_clk cycles allowed from send start to tx_done before abort.
REQ-003 The block SHALL have parameter CFG_RESET, default 8'h00: active configuration after reset (9600 baud, 8 data, no parity, 1 stop, no handshake).
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset; all listed ports follow.
REQ-005 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_a / data_a  in  1 / 8  requester A (NIOS) send request and byte.
REQ-008 req_b / data_b  in  1 / 8  requester B (echo path) send request and byte.
REQ-009 ack_a / ack_b  out  1 / 1  one-cycle pulse: byte of that requester captured.
REQ-010 cfg_write / cfg_data  in  1 / 8  one-cycle request to load a new usr_options value.
REQ-011 tx_done  in  1  one-cycle pulse from transmitter, synchronous to sys_clk: frame finished.
REQ-012 send_enable / data_to_send  out  1 / 8  drive to transmitter.
REQ-013 usr_options  out  8  active configuration, same bit map as the UART option register.
REQ-014 cfg_pending  out  1  shadow configuration waiting to be applied.
REQ-015 last_grant  out  1  0 = A served last, 1 = B served last.
REQ-016 timeout_err  out  1  one-cycle pulse on transmit abort.
REQ-017 idle  out  1  high only in state IDLE.

Function
REQ-018 FSM states SHALL be IDLE, SEND, GAP, with 2-bit encoding.
REQ-019 IDLE with cfg_pending=1: usr_options <= shadow and cfg_pending <= 0; no grant that cycle; stay IDLE.
REQ-020 IDLE with cfg_pending=0 and any req: grant per REQ-021, latch byte into data_to_send, pulse matching ack, set send_enable=1, go SEND.
REQ-021 Arbitration round-robin: single requester wins; both requesting -> winner is requester other than last_grant.
REQ-022 SEND: send_enable held 1, data_to_send stable; timeout counter increments each cycle.
REQ-023 SEND with tx_done=1: send_enable <= 0, counter cleared, go GAP.
REQ-024 SEND, counter reaching TIMEOUT_CYCLES-1 without tx_done: send_enable <= 0, timeout_err pulsed, go GAP.
REQ-025 GAP: stay exactly GAP_CYCLES cycles, then IDLE; GAP_CYCLES=0 -> one cycle in GAP.
REQ-026 cfg_write in any state: shadow <= cfg_data, cfg_pending <= 1; last write before application wins.
REQ-027 cfg_write in same IDLE cycle as application: new value lands in shadow, cfg_pending stays 1, applied next IDLE cycle.
REQ-028 usr_options SHALL never change while send_enable=1.
REQ-029 Requester holds req and data until ack; req still high after ack counts as a new request.
REQ-030 tx_done outside SEND SHALL be ignored.
REQ-031 Minimum spacing between ack pulses: 1 (IDLE) + 1 (SEND) + GAP_CYCLES cycles.

Reset
REQ-032 On reset: state IDLE, usr_options = CFG_RESET, shadow = CFG_RESET, cfg_pending=0, send_enable=0, data_to_send=0, ack_a=ack_b=0, timeout_err=0, last_grant=1 (A wins first tie), idle=1 the cycle after reset deasserts, counters 0.
REQ-033 Reset during SEND or GAP: send_enable low at next edge; captured byte discarded, no ack reissued.

Verification
REQ-034 Reset; req_a=1, data_a=8'h55 -> ack_a pulse at edge 1, send_enable=1 with data_to_send=8'h55 until tx_done, then 16 GAP cycles, idle=1.
REQ-035 req_a and req_b both held, tx_done 10 cycles after each send -> grants alternate A,B,A,B; last_grant toggles each grant.
REQ-036 cfg_write with 8'hC3 during SEND -> usr_options unchanged until tx_done + GAP; becomes 8'hC3 in first IDLE cycle, pending request served the following cycle.
REQ-037 Two cfg_writes 8'h40 then 8'h80 during one SEND -> only 8'h80 applied; cfg_pending clears once.
REQ-038 TIMEOUT_CYCLES=50, no tx_done -> send_enable drops after 50 SEND cycles, one timeout_err pulse, GAP then IDLE.
REQ-039 Reset asserted mid-SEND -> send_enable=0 next edge, usr_options=CFG_RESET, no ack on release.
